// File: rtl/core_deq_arbiter_if.sv
// Core-side and task-unit-side dequeue signals of core_deq_arbiter.
// slave  : arbiter view (takes core requests, drives the task-unit request).
// master : environment view (cores plus task unit).
interface core_deq_arbiter_if #(
  parameter int N_CORES = 4,
  parameter int TTYPE_W = 4,
  parameter int TASK_W  = 128,
  parameter int SLOT_W  = 8
);
  localparam int IDX_W = $clog2(N_CORES);

  logic [N_CORES-1:0]         core_arvalid;
  logic [N_CORES*TTYPE_W-1:0] core_araddr;
  logic [N_CORES-1:0]         core_rvalid;
  logic [TASK_W-1:0]          core_rdata;
  logic [SLOT_W-1:0]          core_rslot;

  logic                       tu_arvalid;
  logic [TTYPE_W-1:0]         tu_araddr;
  logic [IDX_W-1:0]           tu_arcore;
  logic                       tu_rvalid;
  logic [TASK_W-1:0]          tu_rdata;
  logic [SLOT_W-1:0]          tu_rslot;

  modport slave (
    input  core_arvalid, core_araddr, tu_rvalid, tu_rdata, tu_rslot,
    output core_rvalid, core_rdata, core_rslot, tu_arvalid, tu_araddr, tu_arcore
  );

  modport master (
    output core_arvalid, core_araddr, tu_rvalid, tu_rdata, tu_rslot,
    input  core_rvalid, core_rdata, core_rslot, tu_arvalid, tu_araddr, tu_arcore
  );
endinterface

// File: rtl/core_deq_arbiter.sv
// Round-robin arbiter sharing the task unit's single dequeue port among
// N_CORES cores. A grant that waits HOLD_CYCLES without a task yields to
// another requester; a lone requester keeps its grant indefinitely.
// Optional statistics counters are built when CORE_DEQ_ARB_STATS_EN is defined;
// otherwise stat_grants_o / stat_yields_o are tied to 0.
//
// state     | meaning
// ----------+--------------------------------------------------
// S_IDLE    | no grant held; pick next requester after ptr
// S_GRANTED | grant g held; core g's request forwarded to TU
module core_deq_arbiter #(
  parameter int N_CORES     = 4,
  parameter int TTYPE_W     = 4,
  parameter int TASK_W      = 128,
  parameter int SLOT_W      = 8,
  parameter int HOLD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rstn,
  core_deq_arbiter_if.slave bus,
  output logic [31:0]       stat_grants_o,
  output logic [31:0]       stat_yields_o
);
  localparam int IDX_W  = $clog2(N_CORES);
  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic {S_IDLE, S_GRANTED} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [N_CORES-1:0] g_onehot;
  logic               granted;
  logic               req_g;
  logic               other_req;
  logic               deq_done;
  logic               yield_now;
  logic [TASK_W-1:0]  rdata_w;
  logic [SLOT_W-1:0]  rslot_w;
  logic [TTYPE_W-1:0] araddr_arr [N_CORES];

  // Task data and slot are broadcast to every core regardless of state.
  assign rdata_w         = bus.tu_rdata;
  assign rslot_w         = bus.tu_rslot;
  assign bus.core_rdata  = rdata_w;
  assign bus.core_rslot  = rslot_w;

  for (genvar i = 0; i < N_CORES; i++) begin : g_araddr
    assign araddr_arr[i] = bus.core_araddr[i*TTYPE_W +: TTYPE_W];
  end

  // Round-robin search: first requester strictly after ptr, wrapping.
  always_comb begin
    int unsigned      idx;
    logic [IDX_W-1:0] idx_w;
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 1; k <= N_CORES; k++) begin
      idx   = (int'(ptr_q) + k) % N_CORES;
      idx_w = IDX_W'(idx);
      if (!sel_found && bus.core_arvalid[idx_w]) begin
        sel_found = 1'b1;
        sel_idx   = idx_w;
      end
    end
  end

  // Next-state logic and combinational grant/response routing.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    g_d       = g_q;
    hold_d    = hold_q;

    granted   = (state_q == S_GRANTED);
    g_onehot  = N_CORES'(1) << g_q;
    req_g     = bus.core_arvalid[g_q];
    other_req = |(bus.core_arvalid & ~g_onehot);
    deq_done  = granted & req_g & bus.tu_rvalid;
    yield_now = granted & req_g & ~deq_done & (hold_q == HOLD_MAX) & other_req;

    bus.tu_arvalid  = granted & req_g;
    bus.tu_araddr   = granted ? araddr_arr[g_q] : '0;
    bus.tu_arcore   = granted ? g_q : '0;
    bus.core_rvalid = deq_done ? g_onehot : '0;

    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          g_d     = sel_idx;
          hold_d  = '0;
          state_d = S_GRANTED;
        end
      end
      S_GRANTED: begin
        // Completion, abort drop and timeout yield all release the grant.
        if (deq_done || !req_g || yield_now) begin
          ptr_d   = g_q;
          state_d = S_IDLE;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      ptr_q   <= IDX_W'(N_CORES - 1);
      g_q     <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      hold_q  <= hold_d;
    end
  end

`ifdef CORE_DEQ_ARB_STATS_EN
  logic [31:0] grants_q;
  logic [31:0] yields_q;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      grants_q <= '0;
      yields_q <= '0;
    end else begin
      if (deq_done)  grants_q <= grants_q + 32'd1;
      if (yield_now) yields_q <= yields_q + 32'd1;
    end
  end

  assign stat_grants_o = grants_q;
  assign stat_yields_o = yields_q;
`else
  assign stat_grants_o = '0;
  assign stat_yields_o = '0;
`endif

endmodule
